ccg_tt_sweep: RTL and testbench

Parametrised sequential successor to the generated combinational netlists (4-in/6-out class). It holds an N_IN-input, N_OUT-output Boolean function as a programmable truth table. On request it sweeps every input vector exhaustively, streams the registered outputs, and compacts them into a MISR signature. The signature is the functional fingerprint used to compare a generated circuit against its truth table.

---
 rtl/ccg_tt_sweep.sv | 172 +++++++++++++++++
 tb/tb_ccg_tt_sweep.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_tt_sweep.sv
// Programmable N_IN-in / N_OUT-out truth table. It sweeps every input vector, streams the outputs and compacts them into a MISR signature.
// Optional build macro CCG_TT_GRAY_SWEEP_EN selects Gray-order sweeping. The default is binary order.
module ccg_tt_sweep #(
  parameter int               N_IN  = 4,
  parameter int               N_OUT = 6,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h100B
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(N_OUT)-1:0] cfg_sel,
  input  logic [N_IN-1:0]          cfg_addr,
  input  logic                     cfg_bit,
  input  logic                     start,
  output logic                     busy,
  output logic [N_IN-1:0]          x,
  output logic [N_OUT-1:0]         f,
  output logic                     f_valid,
  output logic                     done,
  output logic [SIG_W-1:0]         signature
);

  localparam int              DEPTH   = 1 << N_IN;
  localparam logic [N_IN-1:0] CNT_MAX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] CNT_ONE = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [DEPTH-1:0]   tt_r [N_OUT];
  logic [N_IN-1:0]    cnt_r;
  logic [N_IN-1:0]    x_r;
  logic [N_OUT-1:0]   f_r, f_nxt_s;
  logic               f_valid_r, done_r, busy_r;
  logic [SIG_W-1:0]   sig_r;
  logic               wr_ok_s;

  function automatic logic [N_IN-1:0] sweep_vec(input logic [N_IN-1:0] c);
`ifdef CCG_TT_GRAY_SWEEP_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [N_OUT-1:0] d);
    return (s << 1) ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ SIG_W'(d);
  endfunction

  assign wr_ok_s = (state_r == S_IDLE) && cfg_we && (int'(cfg_sel) < N_OUT);

  // Truth-table lookup for the vector currently presented on x.
  always_comb begin
    f_nxt_s = '0;
    for (int o = 0; o < N_OUT; o++) begin
      f_nxt_s[o] = tt_r[o][x_r];
    end
  end

  // Truth-table storage; only written while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_OUT; o++) begin
        tt_r[o] <= '0;
      end
    end else if (wr_ok_s) begin
      tt_r[cfg_sel][cfg_addr] <= cfg_bit;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_SWEEP;
        else       state_nxt_s = S_IDLE;
      end
      S_SWEEP: begin
        if (cnt_r == CNT_MAX) state_nxt_s = S_FLUSH;
        else                  state_nxt_s = S_SWEEP;
      end
      S_FLUSH: state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Sweep datapath: counter, presented vector, output stream and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      x_r       <= '0;
      f_r       <= '0;
      f_valid_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          f_r       <= '0;
          f_valid_r <= 1'b0;
          done_r    <= 1'b0;
          if (start) begin
            cnt_r  <= '0;
            x_r    <= sweep_vec('0);
            busy_r <= 1'b1;
          end
        end
        S_SWEEP: begin
          f_r       <= f_nxt_s;
          f_valid_r <= 1'b1;
          cnt_r     <= cnt_r + CNT_ONE;
          // x holds the last vector through FLUSH while the counter wraps
          if (cnt_r != CNT_MAX) x_r <= sweep_vec(cnt_r + CNT_ONE);
        end
        S_FLUSH: begin
          f_r       <= '0;
          f_valid_r <= 1'b0;
          done_r    <= 1'b1;
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          cnt_r     <= '0;
          x_r       <= '0;
          f_r       <= '0;
          f_valid_r <= 1'b0;
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // MISR: cleared by an accepted start, absorbs every valid output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= '0;
    end else if ((state_r == S_IDLE) && start) begin
      sig_r <= '0;
    end else if (f_valid_r) begin
      sig_r <= misr_next(sig_r, f_r);
    end
  end

  assign busy      = busy_r;
  assign x         = x_r;
  assign f         = f_r;
  assign f_valid   = f_valid_r;
  assign done      = done_r;
  assign signature = sig_r;

endmodule

// File: tb/tb_ccg_tt_sweep.sv
// Directed self-checking bench for ccg_tt_sweep (N_IN=4, N_OUT=6, SIG_W=16).
module tb_ccg_tt_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [3:0]  cfg_addr = 4'd0;
  logic        cfg_bit = 1'b0;
  logic        start = 1'b0;
  logic        busy, f_valid, done;
  logic [3:0]  x;
  logic [5:0]  f;
  logic [15:0] signature;

  int checks = 0;
  int failures = 0;

  logic [3:0]  x_tr    [0:19];
  logic [5:0]  f_tr    [0:19];
  logic        fv_tr   [0:19];
  logic        done_tr [0:19];
  logic        busy_tr [0:19];
  logic [15:0] sig_tr  [0:19];

  ccg_tt_sweep dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .start(start), .busy(busy),
    .x(x), .f(f), .f_valid(f_valid), .done(done), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_x(input int k);
    logic [3:0] c;
    c = 4'(k);
`ifdef CCG_TT_GRAY_SWEEP_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [3:0] addr, input logic b);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_bit = b;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Records cycles 0..19 relative to the start cycle; returns at the cycle-19 negedge.
  task automatic do_sweep(input bit disturb, input bit wr0, input logic [3:0] wr_addr);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      x_tr[c] = x; f_tr[c] = f; fv_tr[c] = f_valid;
      done_tr[c] = done; busy_tr[c] = busy; sig_tr[c] = signature;
      start    = (c == 0) || (disturb && c == 5);
      cfg_we   = (wr0 && c == 0) || (disturb && c == 6);
      cfg_sel  = 3'd0;
      cfg_addr = (c == 0) ? wr_addr : 4'd3;
      cfg_bit  = 1'b1;
    end
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, x, f, f_valid, done, signature} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b x=%h f=%h fv=%b done=%b sig=%h exp all zero",
               busy, x, f, f_valid, done, signature);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_table();
    apply_reset();
    do_sweep(1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (x_tr[k+1] !== exp_x(k)) begin
        failures++;
        $display("FAIL zero_x cycle=%0d got=%h exp=%h", k + 1, x_tr[k+1], exp_x(k));
      end
    end
    checks++;
    if (x_tr[17] !== exp_x(15)) begin
      failures++;
      $display("FAIL zero_x_flush got=%h exp=%h", x_tr[17], exp_x(15));
    end
    for (int c = 1; c < 20; c++) begin
      checks++;
      if (fv_tr[c] !== (c >= 2 && c <= 17) || done_tr[c] !== (c == 18) ||
          busy_tr[c] !== (c >= 1 && c <= 18) || f_tr[c] !== 6'd0) begin
        failures++;
        $display("FAIL zero_flags cycle=%0d got fv=%b done=%b busy=%b f=%h exp fv=%b done=%b busy=%b f=00",
                 c, fv_tr[c], done_tr[c], busy_tr[c], f_tr[c],
                 (c >= 2 && c <= 17), (c == 18), (c >= 1 && c <= 18));
      end
    end
    checks++;
    if (sig_tr[18] !== 16'h0000 || sig_tr[19] !== 16'h0000) begin
      failures++;
      $display("FAIL zero_sig got=%h/%h exp=0000", sig_tr[18], sig_tr[19]);
    end
  endtask

  task automatic test_single_bit(input logic [3:0] addr, input logic [15:0] exp_sig);
    int vis;
    vis = 0;
    for (int k = 0; k < 16; k++) if (exp_x(k) == addr) vis = k;
    apply_reset();
    cfg_write(3'd0, addr, 1'b1);
    do_sweep(1'b0, 1'b0, 4'd0);
    for (int c = 1; c < 20; c++) begin
      checks++;
      if (f_tr[c] !== ((c == vis + 2) ? 6'h01 : 6'h00)) begin
        failures++;
        $display("FAIL single_f addr=%0d cycle=%0d got=%h exp=%h", addr, c, f_tr[c],
                 (c == vis + 2) ? 6'h01 : 6'h00);
      end
    end
    checks++;
    if (sig_tr[18] !== exp_sig || done_tr[18] !== 1'b1) begin
      failures++;
      $display("FAIL single_sig addr=%0d got=%h done=%b exp=%h done=1", addr, sig_tr[18], done_tr[18], exp_sig);
    end
  endtask

  task automatic test_misr_feedback();
    apply_reset();
    for (int a = 0; a < 16; a++) cfg_write(3'd5, 4'(a), 1'b1);
    do_sweep(1'b0, 1'b0, 4'd0);
    checks++;
    if (sig_tr[18] !== 16'h1F32) begin
      failures++;
      $display("FAIL misr_feedback got=%h exp=1f32", sig_tr[18]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp15;
`ifdef CCG_TT_GRAY_SWEEP_EN
    exp15 = 16'h0020;
`else
    exp15 = 16'h0001;
`endif
    apply_reset();
    do_sweep(1'b1, 1'b0, 4'd0);
    for (int c = 1; c < 20; c++) begin
      checks++;
      if (done_tr[c] !== (c == 18)) begin
        failures++;
        $display("FAIL b2b_done1 cycle=%0d got=%b exp=%b", c, done_tr[c], (c == 18));
      end
    end
    checks++;
    if (sig_tr[18] !== 16'h0000 || busy_tr[19] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got sig=%h busy19=%b exp sig=0000 busy19=0", sig_tr[18], busy_tr[19]);
    end
    do_sweep(1'b0, 1'b1, 4'd15);
    checks++;
    if (done_tr[18] !== 1'b1 || sig_tr[18] !== exp15 || sig_tr[19] !== exp15) begin
      failures++;
      $display("FAIL b2b_second got done=%b sig=%h hold=%h exp done=1 sig=%h", done_tr[18], sig_tr[18], sig_tr[19], exp15);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [15:0] exp15;
    int dseen;
`ifdef CCG_TT_GRAY_SWEEP_EN
    exp15 = 16'h0020;
`else
    exp15 = 16'h0001;
`endif
    apply_reset();
    for (int a = 0; a < 16; a++) cfg_write(3'd0, 4'(a), 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 6; c++) @(negedge clk);
    checks++;
    if (x !== exp_x(5) || f !== 6'h01 || signature === 16'h0000) begin
      failures++;
      $display("FAIL midrst_pre got x=%h f=%h sig=%h exp x=%h f=01 sig nonzero", x, f, signature, exp_x(5));
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, x, f, f_valid, done, signature} !== 29'd0) begin
      failures++;
      $display("FAIL midrst_outputs got busy=%b x=%h f=%h fv=%b done=%b sig=%h exp all zero",
               busy, x, f, f_valid, done, signature);
    end
    dseen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    checks++;
    if (dseen !== 0) begin
      failures++;
      $display("FAIL midrst_no_done got=%0d exp=0", dseen);
    end
    do_sweep(1'b0, 1'b1, 4'd15);
    checks++;
    if (done_tr[18] !== 1'b1 || sig_tr[18] !== exp15) begin
      failures++;
      $display("FAIL midrst_restart got done=%b sig=%h exp done=1 sig=%h", done_tr[18], sig_tr[18], exp15);
    end
  endtask

  initial begin
    test_reset();
    test_zero_table();
`ifdef CCG_TT_GRAY_SWEEP_EN
    test_single_bit(4'd15, 16'h0020);
    test_single_bit(4'd14, 16'h0010);
    test_single_bit(4'd8,  16'h0001);
`else
    test_single_bit(4'd15, 16'h0001);
    test_single_bit(4'd14, 16'h0002);
    test_single_bit(4'd8,  16'h0080);
`endif
    test_misr_feedback();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
